up_interp_x2_nch: RTL

UP_INTERP_X2_NCH -- requirements
Module: up_interp_x2_nch

---
 rtl/duc_pkg.sv | 40 ++++
 rtl/up_interp_x2_nch_if.sv | 31 +++
 rtl/hb_mac.sv | 73 +++++++
 rtl/up_interp_x2_nch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/duc_pkg.sv
// Shared types and half-band coefficient tables for the x2 up-sampling interpolator.
package duc_pkg;

    localparam int CW = 16;

    typedef enum logic [1:0] {
        MODE_HB   = 2'd0,
        MODE_ZS   = 2'd1,
        MODE_HOLD = 2'd2,
        MODE_BYP  = 2'd3
    } mode_e;

    // Even-phase taps G[k] in Q1.15 with the x2 gain folded in (each set sums to 1.0).
    // Only k < m is stored; G[2m-1-k] mirrors it.
    function automatic logic signed [CW-1:0] hb_coef(input int m, input int k);
        logic signed [CW-1:0] c;
        c = 16'sd0;
        case (m)
            1: c = 16'sd16384;
            2: begin
                case (k)
                    0:       c = -16'sd2048;
                    1:       c = 16'sd18432;
                    default: c = 16'sd0;
                endcase
            end
            3: begin
                case (k)
                    0:       c = 16'sd384;
                    1:       c = -16'sd3200;
                    2:       c = 16'sd19200;
                    default: c = 16'sd0;
                endcase
            end
            default: c = 16'sd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/up_interp_x2_nch_if.sv
// Sample/sideband bus of the x2 interpolator; the design is the slave, the driver the master.
interface up_interp_x2_nch_if #(
    parameter int DW  = 16,
    parameter int NCH = 4
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           i_vld;
    logic [CHW-1:0] i_ch;
    logic           i_ca;
    logic [DW-1:0]  i_data;
    logic [1:0]     i_mode;
    logic           i_clr_flags;
    logic           o_vld;
    logic [CHW-1:0] o_ch;
    logic           o_ca;
    logic           o_phase;
    logic [DW-1:0]  o_data;
    logic           o_sat;
    logic           o_err;

    modport master (
        output i_vld, i_ch, i_ca, i_data, i_mode, i_clr_flags,
        input  o_vld, o_ch, o_ca, o_phase, o_data, o_sat, o_err
    );

    modport slave (
        input  i_vld, i_ch, i_ca, i_data, i_mode, i_clr_flags,
        output o_vld, o_ch, o_ca, o_phase, o_data, o_sat, o_err
    );
endinterface

// File: rtl/hb_mac.sv
// Even-phase half-band MAC: symmetric pre-add, multiply, registered sum, round half-up, saturate.
// Two register stages; the rounded result is valid in the cycle after the sum register.
module hb_mac
    import duc_pkg::*;
#(
    parameter int DW   = 16,
    parameter int M    = 3,
    parameter int ACCW = DW + CW + 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [2*M*DW-1:0]    i_win,
    output logic signed [DW-1:0] o_y,
    output logic                 o_sat
);
    localparam int TAPS = 2 * M;
    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [ACCW-1:0] RND  = ACCW'(32'sd16384);

    logic signed [ACCW-1:0] prod_d [M];
    logic signed [ACCW-1:0] prod_q [M];
    logic signed [ACCW-1:0] acc_d, acc_q;
    logic signed [ACCW-1:0] rnd_s;
    logic signed [DW:0]     a_s, b_s, pre_s;

    // Pre-add each symmetric tap pair, then scale by its shared coefficient.
    always_comb begin
        a_s   = '0;
        b_s   = '0;
        pre_s = '0;
        for (int k = 0; k < M; k++) begin
            a_s       = (DW+1)'(signed'(i_win[k*DW +: DW]));
            b_s       = (DW+1)'(signed'(i_win[(TAPS-1-k)*DW +: DW]));
            pre_s     = a_s + b_s;
            prod_d[k] = ACCW'(pre_s) * ACCW'(hb_coef(M, k));
        end
    end

    // Adder tree over the registered products.
    always_comb begin
        acc_d = '0;
        for (int k = 0; k < M; k++) begin
            acc_d = acc_d + prod_q[k];
        end
    end

    // Product and sum pipeline registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < M; k++) prod_q[k] <= '0;
            acc_q <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    // Round half-up to integer, clamp to the DW-bit range.
    always_comb begin
        rnd_s = (acc_q + RND) >>> 15;
        if (rnd_s > MAXV) begin
            o_y   = MAXV[DW-1:0];
            o_sat = 1'b1;
        end else if (rnd_s < MINV) begin
            o_y   = MINV[DW-1:0];
            o_sat = 1'b1;
        end else begin
            o_y   = rnd_s[DW-1:0];
            o_sat = 1'b0;
        end
    end
endmodule

// File: rtl/up_interp_x2_nch.sv
// Two-times up-sampling interpolator for NCH time-multiplexed channels: delay lines,
// input protocol check, sideband pipeline and even/odd phase sequencing around hb_mac.
module up_interp_x2_nch
    import duc_pkg::*;
#(
    parameter int DW  = 16,
    parameter int NCH = 4,
    parameter int M   = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    up_interp_x2_nch_if.slave bus
);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TAPS = 2 * M;
    localparam int ACCW = DW + CW + 4;
    localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);

    logic signed [DW-1:0] dl_q [NCH][TAPS];
    logic signed [DW-1:0] dl_d [NCH][TAPS];
    logic signed [DW-1:0] row_s [TAPS];
    logic [TAPS*DW-1:0]   win_s;
    logic                 accept_s, viol_s, sat_ev_s, hb_sat_s;
    logic signed [DW-1:0] hb_y_s;
    logic                 last_q, last_d;

    logic                 s1_vld_q, s1_vld_d, s1_ca_q, s1_ca_d;
    logic [CHW-1:0]       s1_ch_q, s1_ch_d;
    mode_e                s1_mode_q, s1_mode_d;
    logic                 s2_vld_q, s2_vld_d, s2_ca_q, s2_ca_d;
    logic [CHW-1:0]       s2_ch_q, s2_ch_d;
    mode_e                s2_mode_q, s2_mode_d;
    logic signed [DW-1:0] s2_x0_q, s2_x0_d, s2_xm_q, s2_xm_d;
    logic                 s3_vld_q, s3_vld_d, s3_ca_q, s3_ca_d;
    logic [CHW-1:0]       s3_ch_q, s3_ch_d;
    mode_e                s3_mode_q, s3_mode_d;
    logic signed [DW-1:0] s3_x0_q, s3_x0_d, s3_xm_q, s3_xm_d;
    logic                 od_vld_q, od_vld_d, od_ca_q, od_ca_d;
    logic [CHW-1:0]       od_ch_q, od_ch_d;
    logic signed [DW-1:0] od_data_q, od_data_d;
    logic                 o_vld_q, o_vld_d, o_ca_q, o_ca_d, o_phase_q, o_phase_d;
    logic [CHW-1:0]       o_ch_q, o_ch_d;
    logic signed [DW-1:0] o_data_q, o_data_d;
    logic                 sat_q, sat_d, err_q, err_d;

    // A sample is taken only in range and not right after another accepted sample.
    always_comb begin
        accept_s = bus.i_vld && !last_q && ({1'b0, bus.i_ch} < NCH_L);
        viol_s   = bus.i_vld && !accept_s;
        last_d   = accept_s;
    end

    // Shift the addressed channel's delay line on acceptance, regardless of mode.
    always_comb begin
        dl_d = dl_q;
        for (int c = 0; c < NCH; c++) begin
            if (accept_s && (bus.i_ch == CHW'(c))) begin
                for (int t = TAPS - 1; t > 0; t--) dl_d[c][t] = dl_q[c][t-1];
                dl_d[c][0] = signed'(bus.i_data);
            end else begin
                dl_d[c] = dl_q[c];
            end
        end
    end

    // Select the freshly shifted delay line of the stage-1 channel as the MAC window.
    always_comb begin
        win_s = '0;
        for (int t = 0; t < TAPS; t++) row_s[t] = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int t = 0; t < TAPS; t++) row_s[t] = (s1_ch_q == CHW'(c)) ? dl_q[c][t] : row_s[t];
        end
        for (int t = 0; t < TAPS; t++) win_s[t*DW +: DW] = row_s[t];
    end

    hb_mac #(.DW(DW), .M(M), .ACCW(ACCW)) u_hb_mac (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_win (win_s),
        .o_y   (hb_y_s),
        .o_sat (hb_sat_s)
    );

    // Sideband pipeline aligned with the MAC, then even/odd phase sequencing and sticky flags.
    always_comb begin
        s1_vld_d  = accept_s;
        s1_ch_d   = accept_s ? bus.i_ch : s1_ch_q;
        s1_ca_d   = accept_s ? bus.i_ca : s1_ca_q;
        s1_mode_d = accept_s ? mode_e'(bus.i_mode) : s1_mode_q;
        s2_vld_d  = s1_vld_q;
        s2_ch_d   = s1_ch_q;
        s2_ca_d   = s1_ca_q;
        s2_mode_d = s1_mode_q;
        s2_x0_d   = row_s[0];
        s2_xm_d   = row_s[M-1];
        s3_vld_d  = s2_vld_q;
        s3_ch_d   = s2_ch_q;
        s3_ca_d   = s2_ca_q;
        s3_mode_d = s2_mode_q;
        s3_x0_d   = s2_x0_q;
        s3_xm_d   = s2_xm_q;
        od_vld_d  = 1'b0;
        od_ch_d   = '0;
        od_ca_d   = 1'b0;
        od_data_d = '0;
        o_vld_d   = 1'b0;
        o_ch_d    = '0;
        o_ca_d    = 1'b0;
        o_phase_d = 1'b0;
        o_data_d  = '0;
        sat_ev_s  = 1'b0;
        if (s3_vld_q) begin
            o_vld_d = 1'b1;
            o_ch_d  = s3_ch_q;
            o_ca_d  = s3_ca_q;
            od_ch_d = s3_ch_q;
            od_ca_d = s3_ca_q;
            case (s3_mode_q)
                MODE_HB: begin
                    o_data_d  = hb_y_s;
                    sat_ev_s  = hb_sat_s;
                    od_vld_d  = 1'b1;
                    od_data_d = s3_xm_q;
                end
                MODE_ZS: begin
                    o_data_d  = s3_x0_q;
                    od_vld_d  = 1'b1;
                    od_data_d = '0;
                end
                MODE_HOLD: begin
                    o_data_d  = s3_x0_q;
                    od_vld_d  = 1'b1;
                    od_data_d = s3_x0_q;
                end
                MODE_BYP: begin
                    o_data_d  = s3_x0_q;
                    od_vld_d  = 1'b0;
                end
                default: begin
                    o_data_d  = '0;
                    od_vld_d  = 1'b0;
                end
            endcase
        end else if (od_vld_q) begin
            o_vld_d   = 1'b1;
            o_phase_d = 1'b1;
            o_ch_d    = od_ch_q;
            o_ca_d    = od_ca_q;
            o_data_d  = od_data_q;
        end else begin
            o_vld_d   = 1'b0;
        end
        sat_d = sat_ev_s | (sat_q & ~bus.i_clr_flags);
        err_d = viol_s   | (err_q & ~bus.i_clr_flags);
    end

    // State registers; reset discards delay lines, in-flight samples and flags.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int c = 0; c < NCH; c++) begin
                for (int t = 0; t < TAPS; t++) dl_q[c][t] <= '0;
            end
            last_q    <= 1'b0;
            s1_vld_q  <= 1'b0; s1_ch_q <= '0; s1_ca_q <= 1'b0; s1_mode_q <= MODE_HB;
            s2_vld_q  <= 1'b0; s2_ch_q <= '0; s2_ca_q <= 1'b0; s2_mode_q <= MODE_HB;
            s2_x0_q   <= '0;   s2_xm_q <= '0;
            s3_vld_q  <= 1'b0; s3_ch_q <= '0; s3_ca_q <= 1'b0; s3_mode_q <= MODE_HB;
            s3_x0_q   <= '0;   s3_xm_q <= '0;
            od_vld_q  <= 1'b0; od_ch_q <= '0; od_ca_q <= 1'b0; od_data_q <= '0;
            o_vld_q   <= 1'b0; o_ch_q  <= '0; o_ca_q  <= 1'b0; o_phase_q <= 1'b0;
            o_data_q  <= '0;   sat_q   <= 1'b0; err_q <= 1'b0;
        end else begin
            dl_q      <= dl_d;
            last_q    <= last_d;
            s1_vld_q  <= s1_vld_d; s1_ch_q <= s1_ch_d; s1_ca_q <= s1_ca_d; s1_mode_q <= s1_mode_d;
            s2_vld_q  <= s2_vld_d; s2_ch_q <= s2_ch_d; s2_ca_q <= s2_ca_d; s2_mode_q <= s2_mode_d;
            s2_x0_q   <= s2_x0_d;  s2_xm_q <= s2_xm_d;
            s3_vld_q  <= s3_vld_d; s3_ch_q <= s3_ch_d; s3_ca_q <= s3_ca_d; s3_mode_q <= s3_mode_d;
            s3_x0_q   <= s3_x0_d;  s3_xm_q <= s3_xm_d;
            od_vld_q  <= od_vld_d; od_ch_q <= od_ch_d; od_ca_q <= od_ca_d; od_data_q <= od_data_d;
            o_vld_q   <= o_vld_d;  o_ch_q  <= o_ch_d;  o_ca_q  <= o_ca_d;  o_phase_q <= o_phase_d;
            o_data_q  <= o_data_d; sat_q   <= sat_d;   err_q   <= err_d;
        end
    end

    assign bus.o_vld   = o_vld_q;
    assign bus.o_ch    = o_ch_q;
    assign bus.o_ca    = o_ca_q;
    assign bus.o_phase = o_phase_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_sat   = sat_q;
    assign bus.o_err   = err_q;
endmodule
